// File: rtl/fifo_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sci_acc_pkg
//  Description : Shared widths, depths and state encoding for the result
//                path (result FIFO and its scheduler).
//  Revision    : 1.0 - initial release
// ============================================================================
package sci_acc_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int NUM_MODES      = 2;
    localparam int RES_WIDTH      = 2;
    localparam int FIFO_DEPTH     = 8;
    localparam int FIFO_CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_sched_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Grants the first asserted
//                request at or after ptr, wrapping past NUM_REQ-1 to 0.
//  Ports       : req     - request vector
//                ptr     - highest-priority lane this cycle
//                gnt     - one-hot grant (all zero when no request)
//                gnt_idx - index of the granted lane (0 when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = IDX_W'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sched
//  Description : Shares the single-port-per-cycle result FIFO between
//                NUM_REQ lanes and one downstream consumer. Round-robin lane
//                writes, interleaved reads, own occupancy tracking, FIFO
//                clear sequencing after reset / flush, and a sticky flag for
//                any disagreement with the FIFO's EMPTY/FULL.
//  Ports       : clk, rst_n             - clock, async active-low reset
//                flush                  - pulse: discard all FIFO contents
//                req_valid/req_data     - lane requests and payloads
//                req_ready              - one-hot lane accept
//                fifo_en/fifo_clr_n     - FIFO enable and sync clear
//                fifo_wr/fifo_rd/fifo_din/fifo_dout - FIFO data port
//                fifo_empty/fifo_full   - FIFO status
//                out_valid/out_ready/out_data - downstream handshake
//                occ                    - scheduler occupancy count
//                err                    - sticky occupancy-mismatch flag
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sched
    import sci_acc_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int PAYLOAD_W = DATA_WIDTH + NUM_MODES + RES_WIDTH,
    parameter int DEPTH     = FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           fifo_en,
    output logic                           fifo_clr_n,
    output logic                           fifo_wr,
    output logic                           fifo_rd,
    output logic [PAYLOAD_W-1:0]           fifo_din,
    input  logic [PAYLOAD_W-1:0]           fifo_dout,
    input  logic                           fifo_empty,
    input  logic                           fifo_full,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PAYLOAD_W-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0]     occ,
    output logic                           err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] c_last_ln = IDX_W'(NUM_REQ - 1);

    sched_state_t          state_q, state_d;
    logic                  armed_q, armed_d;       // low only in the first cycle after reset
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  last_wr_q, last_wr_d;   // 1: last FIFO op was a write
    logic                  rd_inflight_q, rd_inflight_d;
    logic                  op_prev_q, op_prev_d;   // FIFO op issued in the previous cycle
    logic                  out_valid_q, out_valid_d;
    logic [PAYLOAD_W-1:0]  out_data_q, out_data_d;
    logic [CNT_W-1:0]      occ_q, occ_d;
    logic                  err_q, err_d;

    logic [NUM_REQ-1:0]    w_gnt;
    logic [IDX_W-1:0]      w_gnt_idx;
    logic                  w_run, w_wr_elig, w_rd_elig, w_do_wr, w_do_rd;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // Op selection. Flush suppresses both ops: anything moved this cycle
    // would be wiped by the clear that follows.
    always_comb begin
        w_run     = (state_q == RUN);
        w_wr_elig = w_run && !flush && (|req_valid) && (occ_q < c_depth);
        w_rd_elig = w_run && !flush && (occ_q != '0) && !rd_inflight_q &&
                    (!out_valid_q || out_ready);
        w_do_wr   = w_wr_elig && (!w_rd_elig || !last_wr_q);
        w_do_rd   = w_rd_elig && (!w_wr_elig ||  last_wr_q);

        fifo_en    = armed_q;
        fifo_clr_n = w_run;
        fifo_wr    = w_do_wr;
        fifo_rd    = w_do_rd;
        req_ready  = w_do_wr ? w_gnt : '0;
        fifo_din   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_do_wr && w_gnt[i]) begin
                fifo_din = req_data[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        armed_d       = 1'b1;
        ptr_d         = ptr_q;
        last_wr_d     = last_wr_q;
        rd_inflight_d = w_do_rd;
        op_prev_d     = w_do_wr || w_do_rd;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        occ_d         = occ_q;
        err_d         = err_q;

        case (state_q)
            INIT: begin
                occ_d = '0;
                // The clear is only issued once armed; a flush keeps us here.
                if (armed_q && !flush) begin
                    state_d = RUN;
                end
            end
            default: begin
                if (flush) begin
                    state_d = INIT;
                end
                if (w_do_wr) begin
                    occ_d = occ_q + 1'b1;
                end else if (w_do_rd) begin
                    occ_d = occ_q - 1'b1;
                end
                // FIFO flags are compared only once ops have settled.
                if (!op_prev_q &&
                    (((occ_q == '0) != fifo_empty) || ((occ_q == c_depth) != fifo_full))) begin
                    err_d = 1'b1;
                end
            end
        endcase

        if (w_do_wr) begin
            ptr_d     = (w_gnt_idx == c_last_ln) ? '0 : w_gnt_idx + 1'b1;
            last_wr_d = 1'b1;
        end else if (w_do_rd) begin
            last_wr_d = 1'b0;
        end

        if (rd_inflight_q && !flush) begin
            out_data_d  = fifo_dout;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= INIT;
            armed_q       <= 1'b0;
            ptr_q         <= '0;
            last_wr_q     <= 1'b0;
            rd_inflight_q <= 1'b0;
            op_prev_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            occ_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            ptr_q         <= ptr_d;
            last_wr_q     <= last_wr_d;
            rd_inflight_q <= rd_inflight_d;
            op_prev_q     <= op_prev_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            occ_q         <= occ_d;
            err_q         <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign occ       = occ_q;
    assign err       = err_q;

endmodule
`default_nettype wire
